// File: rtl/rx_spi_unpacker.sv
// rx_spi_unpacker: passive SPI sniffer that splits each chip-select burst
// into a 48-bit header (sync word + line start address) and a payload of
// 12-bit samples for the receive frame memory. All outputs are in Cclk.
// Optional build macro: RXUNPACK_ADDR_CHECK_EN (range/alignment check on the
// header address before it is accepted).
module rx_spi_unpacker #(
  parameter logic [31:0] HSYNC_WORD    = 32'h6cf4ae21,
  parameter int          PAYLOAD_WORDS = 80
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        SCLK,
  input  logic        MISO,
  input  logic        CS_n,
  output logic        RxHeader,
  output logic [15:0] RxAdd,
  output logic        RxAddValid,
  output logic [11:0] RxData,
  output logic        RxValid,
  output logic        PktShort
);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_sclk_meta, r_sclk_sync, r_sclk_dly;
  logic        r_miso_meta, r_miso_sync;
  logic        r_cs_meta, r_cs_sync;

  // Header register keeps only 47 bits: the 48th arrives live from MISO
  // in the edge cycle and the full word is compared combinationally.
  logic [46:0] r_hdr;
  logic [5:0]  r_bit_cnt;
  logic [10:0] r_smp_shift;
  logic [3:0]  r_smp_bit;
  logic [6:0]  r_smp_cnt;

  logic        r_rx_header, r_rx_add_valid, r_rx_valid, r_pkt_short;
  logic [15:0] r_rx_add;
  logic [11:0] r_rx_data;

  logic        w_sclk_rise, w_shift_en;
  logic [47:0] w_hdr_full;
  logic [11:0] w_word_full;
  logic        w_hdr_last, w_word_last, w_last_sample;
  logic        w_sync_ok, w_addr_ok;
  logic        w_add_valid_next, w_valid_next, w_short_next;

  assign w_sclk_rise   = r_sclk_sync & ~r_sclk_dly;
  // A CS_n rise beats a coincident SCLK edge: the bit is dropped.
  assign w_shift_en    = w_sclk_rise & ~r_cs_sync;
  assign w_hdr_full    = {r_hdr, r_miso_sync};
  assign w_word_full   = {r_smp_shift, r_miso_sync};
  assign w_hdr_last    = (r_state == S_HEADER) && w_shift_en && (r_bit_cnt == 6'd47);
  assign w_word_last   = (r_state == S_PAYLOAD) && w_shift_en && (r_smp_bit == 4'd11);
  assign w_last_sample = w_word_last && (r_smp_cnt == 7'(PAYLOAD_WORDS - 1));
  assign w_sync_ok     = (w_hdr_full[47:16] == HSYNC_WORD);

`ifdef RXUNPACK_ADDR_CHECK_EN
  assign w_addr_ok = (w_hdr_full[15:0] < 16'h9600) && (w_hdr_full[3:0] == 4'h0);
`else
  assign w_addr_ok = 1'b1;
`endif

  // Two-flop synchronizers on all SPI lines, plus a delay flop for SCLK rise detection
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      r_sclk_meta <= 1'b1;
      r_sclk_sync <= 1'b1;
      r_sclk_dly  <= 1'b1;
      r_miso_meta <= 1'b0;
      r_miso_sync <= 1'b0;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
    end else begin
      r_sclk_meta <= SCLK;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_dly  <= r_sclk_sync;
      r_miso_meta <= MISO;
      r_miso_sync <= r_miso_meta;
      r_cs_meta   <= CS_n;
      r_cs_sync   <= r_cs_meta;
    end
  end

  // State register
  always_ff @(posedge Cclk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; a deasserted chip select always returns to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (!r_cs_sync) w_state_next = S_HEADER;
      S_HEADER:  if (r_cs_sync) w_state_next = S_IDLE;
                 else if (w_hdr_last) w_state_next = S_PAYLOAD;
      S_PAYLOAD: if (r_cs_sync) w_state_next = S_IDLE;
                 else if (w_last_sample) w_state_next = S_DONE;
      S_DONE:    if (r_cs_sync) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output pulse decode; PktShort only when a burst ends before the payload completes
  always_comb begin
    w_add_valid_next = w_hdr_last && w_sync_ok && w_addr_ok;
    w_valid_next     = w_word_last;
    w_short_next     = r_cs_sync && ((r_state == S_HEADER) || (r_state == S_PAYLOAD));
  end

  // Shift registers and counters; everything is cleared on entry to HEADER
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      r_hdr       <= '0;
      r_bit_cnt   <= '0;
      r_smp_shift <= '0;
      r_smp_bit   <= '0;
      r_smp_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_cs_sync) begin
            r_hdr       <= '0;
            r_bit_cnt   <= '0;
            r_smp_shift <= '0;
            r_smp_bit   <= '0;
            r_smp_cnt   <= '0;
          end
        end
        S_HEADER: begin
          if (w_shift_en) begin
            r_hdr     <= w_hdr_full[46:0];
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end
        end
        S_PAYLOAD: begin
          if (w_shift_en) begin
            r_smp_shift <= w_word_full[10:0];
            if (r_smp_bit == 4'd11) begin
              r_smp_bit <= 4'd0;
              r_smp_cnt <= r_smp_cnt + 7'd1;
            end else begin
              r_smp_bit <= r_smp_bit + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; RxAdd and RxData hold between their pulses
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      r_rx_header    <= 1'b0;
      r_rx_add       <= 16'h0000;
      r_rx_add_valid <= 1'b0;
      r_rx_data      <= 12'h000;
      r_rx_valid     <= 1'b0;
      r_pkt_short    <= 1'b0;
    end else begin
      r_rx_header    <= (w_state_next == S_HEADER);
      r_rx_add_valid <= w_add_valid_next;
      r_rx_valid     <= w_valid_next;
      r_pkt_short    <= w_short_next;
      if (w_add_valid_next) r_rx_add  <= w_hdr_full[15:0];
      if (w_valid_next)     r_rx_data <= w_word_full;
    end
  end

  assign RxHeader   = r_rx_header;
  assign RxAdd      = r_rx_add;
  assign RxAddValid = r_rx_add_valid;
  assign RxData     = r_rx_data;
  assign RxValid    = r_rx_valid;
  assign PktShort   = r_pkt_short;

endmodule

// File: tb/tb_rx_spi_unpacker.sv
// Testbench for rx_spi_unpacker: directed SPI bursts, expected pulses are
// queued at stimulus time and a monitor pops/compares on every DUT pulse.
module tb_rx_spi_unpacker;

  localparam logic [31:0] SYNC  = 32'h6cf4ae21;
  localparam int          NWORD = 80;
  localparam int          K_ADDR = 0, K_DATA = 1, K_SHORT = 2;

  logic        Cclk = 1'b0;
  logic        rstn = 1'b0;
  logic        SCLK = 1'b0;
  logic        MISO = 1'b0;
  logic        CS_n = 1'b1;
  logic        RxHeader, RxAddValid, RxValid, PktShort;
  logic [15:0] RxAdd;
  logic [11:0] RxData;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_add = 16'h0000;
  logic        prev_av = 1'b0, prev_v = 1'b0, prev_s = 1'b0;

  rx_spi_unpacker #(.HSYNC_WORD(SYNC), .PAYLOAD_WORDS(NWORD)) dut (
    .Cclk(Cclk), .rstn(rstn), .SCLK(SCLK), .MISO(MISO), .CS_n(CS_n),
    .RxHeader(RxHeader), .RxAdd(RxAdd), .RxAddValid(RxAddValid),
    .RxData(RxData), .RxValid(RxValid), .PktShort(PktShort)
  );

  always #5 Cclk = ~Cclk;

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  return "addr";
      K_DATA:  return "data";
      default: return "short";
    endcase
  endfunction

  // Reference acceptance rule for a 48-bit header
  function automatic bit hdr_accept(input logic [47:0] h);
    bit ok;
    ok = (h[47:16] == SYNC);
`ifdef RXUNPACK_ADDR_CHECK_EN
    ok = ok && (h[15:0] < 16'h9600) && (h[3:0] == 4'h0);
`endif
    return ok;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end else begin
      $display("[TB] ok %s = %h", name, got);
    end
  endtask

  task automatic push(input int k, input logic [15:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input int k, input logic [15:0] got);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %h, want no pulse", kname(k), got);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k || e.val !== got) begin
        n_fail++;
        $display("FAIL sb_%s: got %s %h, want %s %h", kname(k), kname(k), got, kname(e.kind), e.val);
      end else begin
        $display("[TB] %s %h", kname(k), got);
      end
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard
  always @(negedge Cclk) begin
    if (RxAddValid && RxValid) begin
      n_tests++; n_fail++;
      $display("FAIL overlap: got RxAddValid=1 RxValid=1, want not both");
    end
    if ((RxAddValid && prev_av) || (RxValid && prev_v) || (PktShort && prev_s)) begin
      n_tests++; n_fail++;
      $display("FAIL pulse_width: got pulse >1 cycle, want 1 cycle");
    end
    if (RxAddValid) sb_check(K_ADDR, RxAdd);
    if (RxValid)    sb_check(K_DATA, {4'h0, RxData});
    if (PktShort)   sb_check(K_SHORT, 16'h0000);
    prev_av = RxAddValid;
    prev_v  = RxValid;
    prev_s  = PktShort;
  end

  task automatic send_bit(input logic b);
    SCLK = 1'b0;
    MISO = b;
    #30;
    SCLK = 1'b1;
    #30;
  endtask

  task automatic send_word(input logic [11:0] w, input int nbits);
    for (int b = 11; b > 11 - nbits; b--) send_bit(w[b]);
  endtask

  task automatic cs_low();
    CS_n = 1'b0;
    #40;
    chk("rxheader_after_cs_fall", {31'd0, RxHeader}, 32'd1);
  endtask

  task automatic cs_high_drain(input string name);
    SCLK = 1'b0;
    #30;
    CS_n = 1'b1;
    repeat (10) @(negedge Cclk);
    chk({name, "_drain"}, sb_q.size(), 32'd0);
    chk({name, "_rxadd"}, {16'd0, RxAdd}, {16'd0, exp_add});
  endtask

  // Full burst: header, nsamp samples (start, start+1, ...), then extra bits
  task automatic run_burst(input string name, input logic [47:0] hdr, input int nsamp,
                           input logic [11:0] start, input int extra);
    logic [11:0] v;
    cs_low();
    if (hdr_accept(hdr)) begin
      push(K_ADDR, hdr[15:0]);
      exp_add = hdr[15:0];
    end
    for (int i = 0; i < nsamp && i < NWORD; i++) begin
      v = start + 12'(i);
      push(K_DATA, {4'h0, v});
    end
    if (nsamp < NWORD) push(K_SHORT, 16'h0000);
    for (int b = 47; b >= 1; b--) send_bit(hdr[b]);
    chk({name, "_rxheader_bit47"}, {31'd0, RxHeader}, 32'd1);
    send_bit(hdr[0]);
    chk({name, "_rxheader_bit48"}, {31'd0, RxHeader}, 32'd0);
    for (int i = 0; i < nsamp; i++) begin
      v = start + 12'(i);
      send_word(v, 12);
    end
    if (extra > 0) send_word(12'hfff, extra);
    cs_high_drain(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Cclk);
    chk("reset_rxheader",  {31'd0, RxHeader},   32'd0);
    chk("reset_rxadd",     {16'd0, RxAdd},      32'd0);
    chk("reset_rxaddvld",  {31'd0, RxAddValid}, 32'd0);
    chk("reset_rxdata",    {20'd0, RxData},     32'd0);
    chk("reset_rxvalid",   {31'd0, RxValid},    32'd0);
    chk("reset_pktshort",  {31'd0, PktShort},   32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge Cclk);

    run_burst("full",    {SYNC, 16'h00a0}, 80, 12'h001, 0);
    run_burst("nosync",  {32'h93aaaade, 16'h0000}, 80, 12'h100, 0);
    run_burst("short",   {SYNC, 16'h0140}, 30, 12'h200, 5);
    run_burst("clean",   {SYNC, 16'h0190}, 80, 12'h300, 0);
    run_burst("over",    {SYNC, 16'h01e0}, 90, 12'h400, 0);

    // Reset in mid-payload with chip select released at the same time
    cs_low();
    push(K_ADDR, 16'h0230);
    for (int b = 47; b >= 0; b--) send_bit(SYNC[(b > 15) ? b - 16 : 0] & (b > 15) | ((16'h0230 >> b) & (b <= 15)));
    for (int i = 0; i < 10; i++) begin
      push(K_DATA, 16'(12'h500 + 12'(i)));
      send_word(12'h500 + 12'(i), 12);
    end
    send_word(12'habc, 3);
    @(negedge Cclk);
    rstn = 1'b0;
    CS_n = 1'b1;
    SCLK = 1'b0;
    @(negedge Cclk);
    rstn = 1'b1;
    exp_add = 16'h0000;
    chk("rst_mid_rxheader", {31'd0, RxHeader},   32'd0);
    chk("rst_mid_rxadd",    {16'd0, RxAdd},      32'd0);
    chk("rst_mid_rxdata",   {20'd0, RxData},     32'd0);
    chk("rst_mid_rxvalid",  {31'd0, RxValid},    32'd0);
    chk("rst_mid_pktshort", {31'd0, PktShort},   32'd0);
    // SCLK activity with chip select high must produce nothing
    send_word(12'h5a5, 12);
    cs_high_drain("post_reset_idle");
    run_burst("after_rst", {SYNC, 16'h0280}, 80, 12'h600, 0);

    // Address check headers (model decides acceptance for this build)
    run_burst("addr_9600", {SYNC, 16'h9600}, 4, 12'h700, 0);
    run_burst("addr_0050", {SYNC, 16'h0050}, 4, 12'h710, 0);
    run_burst("addr_0057", {SYNC, 16'h0057}, 2, 12'h720, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_spi_unpacker.md
# rx_spi_unpacker

Upstream of the receive frame memory. Passively sniffs the SPI bus between the MCU and the CC1200 while the MCU bursts out the RX FIFO, and splits each chip-select burst into a 48-bit header and a payload of 12-bit pixel samples. It drives the memory stage's `RxHeader`, `RxAdd`/`RxAddValid` and `RxData`/`RxValid` inputs, all in the `Cclk` domain.

## Interface
- `HSYNC_WORD`, default 32'h6cf4ae21: line-header sync word; the header carries the line start address.
- `PAYLOAD_WORDS`, default 80: 12-bit samples per packet (one 0x50-pixel line segment).
- `Cclk` input 1: system clock; SCLK is slower than Cclk/4.
- `rstn` input 1: reset, synchronous, active-low.
- `SCLK` input 1: SPI clock, asynchronous.
- `MISO` input 1: SPI data from the radio, asynchronous; sampled on SCLK rising.
- `CS_n` input 1: SPI chip select, asynchronous, active-low.
- `RxHeader` output 1: high while header bits are being shifted.
- `RxAdd` output 16: last captured header address.
- `RxAddValid` output 1: one-cycle pulse when `RxAdd` is accepted.
- `RxData` output 12: payload sample, MSB first on the wire.
- `RxValid` output 1: one-cycle pulse per sample.
- `PktShort` output 1: one-cycle pulse when CS_n rises before `PAYLOAD_WORDS` samples arrive.

## Operation
- `SCLK`, `MISO` and `CS_n` each pass through 2 flops. The flops are reset to 1, 0 and 1 respectively.
- A third flop on the synchronized SCLK provides rise detection. The "edge cycle" is the Cclk cycle in which a synchronized rise is seen.
- `MISO` is sampled from its synchronizer in the edge cycle.
- State machine: IDLE, HEADER, PAYLOAD, DONE.
  - IDLE -> HEADER: on the cycle synchronized CS_n is low. Clear the 6-bit bit counter, the 48-bit header shift register and the 4-bit sample bit counter.
  - HEADER: shift one bit per edge cycle. After bit 48, compare `hdr[47:16]` with `HSYNC_WORD`.
    - Match: load `RxAdd` <= `hdr[15:0]` and pulse `RxAddValid`.
    - Always go to PAYLOAD.
  - A header whose sync word does not match is still consumed as 48 bits, but no `RxAddValid` is issued. The payload is still unpacked, because the memory stage keeps its own write pointer.
  - PAYLOAD: shift bits into a 12-bit register. On the 12th bit, pulse `RxValid` with the completed word and increment the 7-bit sample counter.
    - When the sample counter reaches `PAYLOAD_WORDS`, go to DONE.
  - DONE: ignore all SCLK edges.
- Synchronized CS_n high in any non-IDLE state -> IDLE, with these effects:
  - A partial header or partial sample is discarded; no pulse is issued.
  - If the state was HEADER or PAYLOAD (that is, not DONE), pulse `PktShort`.
  - CS_n high in IDLE pulses nothing.
- `RxHeader` = registered (state == HEADER).
- Reset values: `RxHeader` 0, `RxAdd` 16'h0000, `RxAddValid` 0, `RxData` 12'h000, `RxValid` 0, `PktShort` 0, state IDLE.
- Reset takes effect at the next Cclk edge, including mid-packet. After reset the block waits in IDLE for the next CS_n falling edge.
  - If CS_n is already low when reset releases, the block enters HEADER on the first cycle and treats subsequent bits as header. Recovery is by the next CS_n high.
- `RxData` holds its value between pulses. `RxAdd` holds until the next accepted header.

## Timing
- Raw CS_n fall -> `RxHeader` high: 3 Cclk cycles.
- Edge cycle of header bit 48 -> `RxAddValid` pulse and `RxHeader` low in the next cycle. The two are coincident.
- Edge cycle of the 12th bit of a sample -> `RxValid` and `RxData` in the next cycle.
- Edge cycle of the last sample -> DONE in the next cycle, coincident with that sample's `RxValid`.
- Raw CS_n rise -> `PktShort` pulse in 3 cycles (2 synchronizer stages plus 1 registered output).
- A CS_n rise and an SCLK edge in the same cycle: CS_n wins and the bit is dropped.
- `RxValid`, `RxAddValid` and `PktShort` are never high for more than 1 cycle.
- `RxAddValid` and `RxValid` are never high in the same cycle.

## Configuration
- `RXUNPACK_ADDR_CHECK_EN`
  - Defined: `RxAddValid` additionally requires `hdr[15:0] < 16'h9600` and `hdr[3:0] == 0`.
  - Defined, and the address check fails: `RxAdd` is not updated and no pulse is issued. The payload is still unpacked.
  - Undefined: only the sync word is checked.

## Test plan
- Full burst, header 32'h6cf4ae21 + 16'h00a0, then 80 samples 12'h001..12'h050:
  - `RxAddValid` once with `RxAdd`=16'h00a0.
  - 80 `RxValid` pulses in order.
  - `RxHeader` low after bit 48.
  - No `PktShort`.
- Header 32'h93aaaade + 16'h0000:
  - `RxHeader` high for 48 bits.
  - No `RxAddValid`.
  - Payload still yields 80 `RxValid` pulses.
- CS_n rises after 30 samples plus 5 bits:
  - Exactly 30 `RxValid` pulses.
  - One `PktShort` pulse.
  - Next burst decodes cleanly.
- 90 samples clocked in one burst: exactly 80 `RxValid` pulses; the extra bits are ignored; no `PktShort`.
- `rstn` low for 1 cycle in mid-payload:
  - All outputs return to reset values.
  - No pulses until the next CS_n fall.
  - The following burst decodes correctly.
- With `RXUNPACK_ADDR_CHECK_EN` defined:
  - Header address 16'h9600: no `RxAddValid`, and `RxAdd` retains its previous value.
  - Header address 16'h0050: pulse with `RxAdd`=16'h0050.
